// File: rtl/wishbone_timer.sv
// wishbone_timer: 32-bit memory-mapped timer on one Wishbone crossbar slave port.
// Provides a prescaled up-counter, a compare match with a sticky status flag,
// one-shot or auto-reload operation, and an optional level interrupt.
//
// Build option: define WB_TIMER_IRQ_EN to make CTRL.IE writable/readable and to
// drive irq = MATCH & IE. Without it, CTRL.IE reads 0 and irq is tied low.
//
// Register map (word index adr[4:2]):
//   0 CTRL     bit0 EN, bit1 RELOAD, bit2 IE
//   1 PRESCALE PRESCALE_WIDTH bits, zero-extended on read
//   2 COUNT    32-bit up-counter
//   3 COMPARE  32-bit compare value
//   4 STATUS   bit0 MATCH, sticky, write 1 to clear
//   5..7       unmapped, answered with err
//
// Handshake: a transfer is requested when cyc & stb are high while the slave
// is idle. At the next clock edge exactly one of ack/err rises for a single
// cycle; writes take effect and read data is captured on that same edge. The
// master may drop cyc/stb after that sampling edge; a strobe still high during
// the response cycle is not sampled again, so at most one transfer completes
// every two cycles. A response already in flight completes even if cyc drops.

module wishbone_timer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 3,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [ADDR_WIDTH-1:0]   adr,
  input  logic [DATA_WIDTH-1:0]   mosi,
  output logic [DATA_WIDTH-1:0]   miso,
  output logic                    ack,
  output logic                    err,
  output logic                    irq,
  output logic                    dbg_state
);

  // Slave response state machine encoding; exported on dbg_state.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } slave_state_t;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_PRESCALE = 3'd1;
  localparam logic [2:0] IDX_COUNT    = 3'd2;
  localparam logic [2:0] IDX_COMPARE  = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  slave_state_t state;

  // Bus decode
  logic [2:0] idx;
  logic       req;
  logic       mapped;
  logic       wr;
  logic       wr_ctrl;
  logic       wr_prescale;
  logic       wr_count;
  logic       wr_compare;
  logic       ctrl_wr_lane;
  logic       status_clr;

  // Programmer-visible state
  logic                      ctrl_en;
  logic                      ctrl_reload;
  logic                      ctrl_ie;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [31:0]               count;
  logic [31:0]               compare;
  logic                      match;

  // Timer internals
  logic [PRESCALE_WIDTH-1:0] psc_cnt;
  logic                      tick;
  logic                      hit;
  logic [31:0]               prescale_ext;
  logic [31:0]               rdata;

  // Address bits below the word index and above the map, plus tag, carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{tag, adr[ADDR_WIDTH-1:5], adr[1:0]};

  // Replace the bytes of old_val selected by be with the matching bytes of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign idx          = adr[4:2];
  assign mapped       = (idx <= IDX_STATUS);
  assign req          = (state == S_IDLE) && cyc && stb && !ack && !err;
  assign wr           = req && we && mapped;
  assign wr_ctrl      = wr && (idx == IDX_CTRL);
  assign wr_prescale  = wr && (idx == IDX_PRESCALE);
  assign wr_count     = wr && (idx == IDX_COUNT);
  assign wr_compare   = wr && (idx == IDX_COMPARE);
  assign ctrl_wr_lane = wr_ctrl && sel[0];
  assign status_clr   = wr && (idx == IDX_STATUS) && sel[0] && mosi[0];

  // A tick fires when the enabled prescaler has counted up to PRESCALE.
  assign tick = ctrl_en && (psc_cnt == prescale);
  assign hit  = tick && (count == compare);

  assign dbg_state = state;

  // Zero-extend PRESCALE to a bus word for readback and byte merging.
  always_comb begin
    prescale_ext = '0;
    prescale_ext[PRESCALE_WIDTH-1:0] = prescale;
  end

  // Read mux over the pre-edge register values.
  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CTRL:     rdata = {29'd0, ctrl_ie, ctrl_reload, ctrl_en};
      IDX_PRESCALE: rdata = prescale_ext;
      IDX_COUNT:    rdata = count;
      IDX_COMPARE:  rdata = compare;
      IDX_STATUS:   rdata = {31'd0, match};
      default:      rdata = '0;
    endcase
  end

  // Slave FSM: accept a strobe in IDLE, answer with a one-cycle ack or err in RESP.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= S_IDLE;
      ack   <= 1'b0;
      err   <= 1'b0;
      miso  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_RESP;
            ack   <= mapped;
            err   <= !mapped;
            miso  <= mapped ? rdata : '0;
          end else begin
            ack  <= 1'b0;
            err  <= 1'b0;
            miso <= '0;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          miso  <= '0;
        end
        default: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          miso  <= '0;
        end
      endcase
    end
  end

  // Prescaler: counts 0..PRESCALE while enabled, restarts on tick, disable or PRESCALE write.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      psc_cnt <= '0;
    end else if (wr_prescale || !ctrl_en || tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  // PRESCALE and COMPARE registers: byte-lane writes from the bus only.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      prescale <= '0;
      compare  <= 32'hFFFF_FFFF;
    end else begin
      if (wr_prescale) prescale <= PRESCALE_WIDTH'(byte_merge(prescale_ext, mosi, sel));
      if (wr_compare)  compare  <= byte_merge(compare, mosi, sel);
    end
  end

  // COUNT: bus write beats the tick; on a match it reloads to 0 or holds for one-shot.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      count <= '0;
    end else if (wr_count) begin
      count <= byte_merge(count, mosi, sel);
    end else if (hit) begin
      if (ctrl_reload) count <= '0;
    end else if (tick) begin
      count <= count + 32'd1;
    end
  end

  // CTRL EN/RELOAD: bus write beats the one-shot self-disable on a match.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
    end else if (ctrl_wr_lane) begin
      ctrl_en     <= mosi[0];
      ctrl_reload <= mosi[1];
    end else if (hit && !ctrl_reload) begin
      ctrl_en <= 1'b0;
    end
  end

  // MATCH: set on a compare hit; a same-edge write-1 clear loses to the set.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      match <= 1'b0;
    end else if (hit) begin
      match <= 1'b1;
    end else if (status_clr) begin
      match <= 1'b0;
    end
  end

`ifdef WB_TIMER_IRQ_EN
  logic match_next;
  logic ie_next;

  // Next-state view of MATCH and IE so irq rises on the same edge as MATCH.
  always_comb begin
    match_next = hit || (match && !status_clr);
    ie_next    = ctrl_wr_lane ? mosi[2] : ctrl_ie;
  end

  // CTRL.IE bit and the registered level interrupt.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ctrl_ie <= 1'b0;
      irq     <= 1'b0;
    end else begin
      ctrl_ie <= ie_next;
      irq     <= match_next && ie_next;
    end
  end
`else
  assign ctrl_ie = 1'b0;
  assign irq     = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_timer.sv
// Testbench for wishbone_timer: directed scenarios plus randomized bus traffic,
// checked by a scoreboard fed from a cycle-level reference model of the timer.
module tb_wishbone_timer;

  localparam int PW = 16;
  localparam logic [31:0] PS_MASK = 32'((64'd1 << PW) - 64'd1);

  // Clock / reset and bus signals
  logic        sys_clk;
  logic        sys_rst;
  logic        cyc, stb, we;
  logic [2:0]  tag;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] mosi;
  logic [31:0] miso;
  logic        ack, err, irq, dbg_state;

  wishbone_timer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TAG_WIDTH(3), .PRESCALE_WIDTH(PW)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cyc(cyc), .stb(stb), .we(we), .tag(tag), .sel(sel), .adr(adr), .mosi(mosi),
    .miso(miso), .ack(ack), .err(err), .irq(irq), .dbg_state(dbg_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Scoreboard: {due edge[31:0], ack, err, miso[31:0]}
  logic [65:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] edge_n = 0;

  // Reference model state
  logic        m_en, m_reload, m_ie, m_match, m_irq, m_resp;
  logic [31:0] m_prescale, m_count, m_compare, m_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] i);
    case (i)
      3'd0: return {29'd0, m_ie, m_reload, m_en};
      3'd1: return m_prescale;
      3'd2: return m_count;
      3'd3: return m_compare;
      3'd4: return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_en = 0; m_reload = 0; m_ie = 0; m_match = 0; m_irq = 0; m_resp = 0;
    m_prescale = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_phase = 0;
  endtask

  // Apply the timer rules for one clock edge, using the bus inputs present at that edge.
  task automatic model_edge();
    logic [2:0]  i;
    logic        acc, mapped, wr, tick, hit;
    logic [31:0] n_count, n_phase;
    logic        n_en, n_reload, n_ie, n_match;
    edge_n = edge_n + 1;
    if (sys_rst) begin
      model_reset();
      return;
    end
    i      = adr[4:2];
    acc    = cyc && stb && !m_resp;
    mapped = (i <= 3'd4);
    wr     = acc && we && mapped;
    tick   = m_en && (m_phase == m_prescale);
    hit    = tick && (m_count == m_compare);
    if (acc) exp_q.push_back({edge_n, mapped, !mapped, mapped ? model_read(i) : 32'd0});
    if ((wr && i == 3'd1) || !m_en || tick) n_phase = 0;
    else n_phase = m_phase + 1;
    n_count = m_count;
    if (wr && i == 3'd2) n_count = merge(m_count, mosi, sel);
    else if (hit) n_count = m_reload ? 32'd0 : m_count;
    else if (tick) n_count = m_count + 1;
    n_en = m_en; n_reload = m_reload; n_ie = m_ie;
    if (wr && i == 3'd0 && sel[0]) begin
      n_en = mosi[0];
      n_reload = mosi[1];
`ifdef WB_TIMER_IRQ_EN
      n_ie = mosi[2];
`endif
    end else if (hit && !m_reload) begin
      n_en = 0;
    end
    n_match = hit ? 1'b1 : ((wr && i == 3'd4 && sel[0] && mosi[0]) ? 1'b0 : m_match);
    if (wr && i == 3'd1) m_prescale = merge(m_prescale, mosi, sel) & PS_MASK;
    if (wr && i == 3'd3) m_compare = merge(m_compare, mosi, sel);
    m_phase = n_phase; m_count = n_count; m_en = n_en; m_reload = n_reload;
    m_ie = n_ie; m_match = n_match; m_irq = n_match & n_ie; m_resp = acc;
  endtask

  // Driver tasks
  task automatic edge_step();
    @(posedge sys_clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) edge_step();
  endtask

  task automatic set_bus(input logic w, input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] a;
    a = $urandom;
    a[4:2] = i;
    cyc = 1; stb = 1; we = w; adr = a; mosi = d; sel = s; tag = 3'($urandom);
  endtask

  task automatic release_bus();
    cyc = 0; stb = 0; we = 0; sel = 4'($urandom); mosi = $urandom;
  endtask

  task automatic xfer(input logic w, input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
    set_bus(w, i, d, s);
    edge_step();
    release_bus();
    edge_step();
  endtask

  task automatic rd(input logic [2:0] i);
    xfer(1'b0, i, $urandom, 4'($urandom));
  endtask

  task automatic wr(input logic [2:0] i, input logic [31:0] d);
    xfer(1'b1, i, d, 4'hF);
  endtask

  task automatic read_all();
    for (int k = 0; k < 5; k++) rd(3'(k));
  endtask

  // Idle until the model says the next edge carries a tick (optionally a compare hit).
  task automatic wait_event(input logic want_hit);
    int n;
    n = 0;
    while (!(m_en && m_phase == m_prescale && (!want_hit || m_count == m_compare)) && n < 200) begin
      edge_step();
      n++;
    end
    check("wait_event", 32'(n < 200), 32'd1);
  endtask

  // Monitor: compare every response against the scoreboard, and idle outputs against the model.
  always @(negedge sys_clk) begin : monitor
    logic [65:0] e;
    if (ack || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {30'd0, ack, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_edge", edge_n, e[65:34]);
        check("resp_ack", 32'(ack), 32'(e[33]));
        check("resp_err", 32'(err), 32'(e[32]));
        check("resp_miso", miso, e[31:0]);
      end
    end else begin
      if (exp_q.size() != 0 && exp_q[0][65:34] <= edge_n) begin
        e = exp_q.pop_front();
        check("resp_missing", {30'd0, ack, err}, {30'd0, e[33:32]});
      end
      check("miso_idle", miso, 32'd0);
    end
    check("irq", 32'(irq), 32'(m_irq));
  end

  initial begin
    logic [2:0]  ri;
    logic [31:0] rdat;
    model_reset();
    sys_rst = 1;
    cyc = 0; stb = 0; we = 0; tag = 0; sel = 0; adr = 0; mosi = 0;
    idle(3);
    sys_rst = 0;

    // Reset values of all registers
    read_all();

    // Auto-reload with prescale 3: COUNT 0,1,2,0 every 4 cycles
    wr(3'd1, 32'd3);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd3);
    for (int k = 0; k < 20; k++) rd(3'd2);
    rd(3'd4);
    wr(3'd4, 32'd1);
    rd(3'd4);
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);

    // One-shot to 5 with interrupt enable
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd5);
    wr(3'd0, 32'd5);
    idle(15);
    rd(3'd2); rd(3'd0); rd(3'd4);
    wr(3'd4, 32'd1);
    rd(3'd4);
    wr(3'd0, 32'd0);

    // Byte-lane write to COUNT
    wr(3'd2, 32'h1122_3344);
    xfer(1'b1, 3'd2, 32'h00AB_0000, 4'b0100);
    rd(3'd2);

    // COUNT write on a tick edge beats the increment
    wr(3'd1, 32'd1);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd0, 32'd3);
    wait_event(1'b0);
    wr(3'd2, 32'h0000_0100);
    rd(3'd2);
    wr(3'd0, 32'd0);

    // Unmapped offsets: err, no state change
    rd(3'd6);
    xfer(1'b1, 3'd5, 32'hFFFF_FFFF, 4'hF);
    xfer(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF);
    read_all();

    // MATCH set and write-1 clear on the same edge: set wins
    wr(3'd4, 32'd1);
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd3);
    wr(3'd0, 32'd7);
    wait_event(1'b1);
    xfer(1'b1, 3'd4, 32'd1, 4'b0001);
    rd(3'd4);

    // CTRL write on a one-shot match edge beats the EN clear
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd4);
    wr(3'd0, 32'd1);
    wait_event(1'b1);
    wr(3'd0, 32'd1);
    rd(3'd0);
    wr(3'd0, 32'd0);

    // Strobe held high: transfers accepted at most every other cycle
    set_bus(1'b0, 3'd2, 32'd0, 4'hF);
    idle(4);
    release_bus();
    edge_step();

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      ri = 3'($urandom_range(0, 7));
      case (ri)
        3'd0: rdat = $urandom_range(0, 7);
        3'd1: rdat = $urandom_range(0, 3);
        3'd2: rdat = $urandom_range(0, 15);
        3'd3: rdat = $urandom_range(0, 20);
        default: rdat = $urandom;
      endcase
      xfer(1'($urandom), ri, rdat, 4'($urandom));
      idle($urandom_range(0, 4));
    end

    // Reset asserted during the response cycle
    wr(3'd3, 32'd9);
    set_bus(1'b1, 3'd2, 32'h1234_5678, 4'hF);
    edge_step();
    release_bus();
    sys_rst = 1;
    edge_step();
    check("rst_resp_ack", {30'd0, ack, err}, 32'd0);
    check("rst_resp_miso", miso, 32'd0);
    sys_rst = 0;
    read_all();

    // Reset coinciding with a strobe: no response
    set_bus(1'b0, 3'd3, 32'd0, 4'hF);
    sys_rst = 1;
    edge_step();
    check("rst_strobe_ack", {30'd0, ack, err}, 32'd0);
    sys_rst = 0;
    release_bus();
    edge_step();
    read_all();

    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
